// File: rtl/nanorisc_multicycle_ctrl.sv
// NanoRisc multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB
// with halt, memory-timeout fault and a saturating retired-instruction count.
module nanorisc_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             RegMemWrite,
    output logic             isSend,
    output logic [1:0]       ULAOp,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_BAD    = 3'd7;

    localparam logic [2:0] OP_SUM  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_LWI  = 3'b011;
    localparam logic [2:0] OP_SWI  = 3'b100;
    localparam logic [2:0] OP_BNE  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_SEND = 3'b111;

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        r_op;
    logic [WAIT_W-1:0] r_wait;
    logic              r_halted;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;

    logic [2:0] w_next;
    logic       w_waiting;
    logic       w_timeout;
    logic       w_fault;
    logic       w_retire;
    logic [1:0] w_alu_op;

    // Stalled memory access: FETCH or MEM without mem_ready this cycle.
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM))
                       && !mem_ready;
    assign w_timeout = w_waiting && (r_wait == WAIT_LAST);
    assign w_fault   = w_timeout || (r_state == S_BAD);

    assign w_retire = (r_state == S_WB)
                    || ((r_state == S_EXEC) && (r_op == OP_BNE))
                    || ((r_state == S_MEM) && (r_op == OP_SWI) && mem_ready);

    always_comb begin
        w_alu_op = 2'b00;
        case (r_op)
            OP_SUB:  w_alu_op = 2'b01;
            OP_MUL:  w_alu_op = 2'b10;
            default: w_alu_op = 2'b00;
        endcase
    end

    // State register and the registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= 3'b000;
            r_wait   <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= opcode;
            end
            r_wait <= w_waiting ? r_wait + WAIT_W'(1) : '0;
            if (w_next == S_HALT) begin
                r_halted <= 1'b1;
            end
            if (w_fault) begin
                r_err <= 1'b1;
            end
            if (w_retire && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                w_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (r_op)
                    OP_LWI, OP_SWI: w_next = S_MEM;
                    OP_BNE:         w_next = S_FETCH;
                    default:        w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_next = (r_op == OP_LWI) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    // Strobes are forced low while reset is held.
    always_comb begin
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 1'b0;
        RegWrite    = 1'b0;
        RegMemWrite = 1'b0;
        isSend      = 1'b0;
        ULAOp       = 2'b00;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        OP_SUM, OP_SUB, OP_MUL: begin
                            ULAOp = w_alu_op;
                        end
                        OP_BNE: begin
                            ULAOp   = 2'b01;
                            PCWrite = !zero;
                            PCSrc   = !zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    MemRead  = (r_op == OP_LWI);
                    MemWrite = (r_op == OP_SWI);
                end
                S_WB: begin
                    case (r_op)
                        OP_SUM, OP_SUB, OP_MUL: begin
                            RegWrite = 1'b1;
                            ULAOp    = w_alu_op;
                        end
                        OP_SEND: begin
                            RegWrite = 1'b1;
                            isSend   = 1'b1;
                        end
                        OP_LWI: begin
                            RegMemWrite = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign halted      = r_halted;
    assign err         = r_err;
    assign instr_count = r_count;
    assign state       = r_state;

endmodule

// File: tb/tb_nanorisc_multicycle_ctrl.sv
// Scoreboard bench for nanorisc_multicycle_ctrl: per-cycle expected state
// and strobes are queued with the stimulus and compared as cycles run.
module tb_nanorisc_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opcode = 3'b000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemRead, MemWrite, IRWrite, PCWrite, PCSrc;
    logic        RegWrite, RegMemWrite, isSend, halted, err;
    logic [1:0]  ULAOp;
    logic [15:0] instr_count;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       start;
        logic       ready;
        logic       zero;
        logic [2:0] op;
    } stim_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [10:0] sb;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];

    nanorisc_multicycle_ctrl #(
        .MEM_TIMEOUT(15),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .opcode(opcode),
        .zero(zero),
        .mem_ready(mem_ready),
        .mem_req(mem_req),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .IRWrite(IRWrite),
        .PCWrite(PCWrite),
        .PCSrc(PCSrc),
        .RegWrite(RegWrite),
        .RegMemWrite(RegMemWrite),
        .isSend(isSend),
        .ULAOp(ULAOp),
        .halted(halted),
        .err(err),
        .instr_count(instr_count),
        .state(state)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Strobe order: req rd wr ir pcw pcs rw rmw snd ulaop[1:0]
    function automatic logic [10:0] mk(
        input logic req, input logic rd, input logic wr,
        input logic ir, input logic pcw, input logic pcs,
        input logic rw, input logic rmw, input logic snd,
        input logic [1:0] ula);
        return {req, rd, wr, ir, pcw, pcs, rw, rmw, snd, ula};
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.st = state;
        o.sb = {mem_req, MemRead, MemWrite, IRWrite, PCWrite, PCSrc,
                RegWrite, RegMemWrite, isSend, ULAOp};
        return o;
    endfunction

    task automatic push(input logic s_start, input logic s_ready,
                        input logic s_zero, input logic [2:0] s_op,
                        input logic [2:0] e_st, input logic [10:0] e_sb);
        stim_t s;
        exp_t  e;
        s.start = s_start;
        s.ready = s_ready;
        s.zero  = s_zero;
        s.op    = s_op;
        e.st    = e_st;
        e.sb    = e_sb;
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic apply();
        stim_t s;
        s = sq.pop_front();
        @(negedge clock);
        reset     = 1'b0;
        start     = s.start;
        mem_ready = s.ready;
        zero      = s.zero;
        opcode    = s.op;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = 3'b000;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    logic [10:0] SB_0, SB_FW, SB_FD;

    task automatic test_reset();
        exp_t e, o;
        do_reset();
        o = obs();
        checks++;
        if (o !== '{3'd0, 11'd0}) begin
            errors++;
            $display("FAIL reset_state: state=%0d strobes=%b, want 0/0", o.st, o.sb);
        end
        checks++;
        if ({halted, err, instr_count} !== 18'd0) begin
            errors++;
            $display("FAIL reset_status: halted=%b err=%b cnt=%0d, want 0 0 0",
                     halted, err, instr_count);
        end
        for (int i = 0; i < 5; i++) push(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SB_0);
        push(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, SB_0);
        push(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, SB_FW);
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_idle: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
    endtask

    task automatic test_mul();
        exp_t e, o;
        push(1'b0, 1'b1, 1'b0, 3'b010, 3'd1, SB_FD);
        push(1'b0, 1'b1, 1'b0, 3'b010, 3'd2, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b010, 3'd3, mk(0,0,0,0,0,0,0,0,0,2'b10));
        push(1'b0, 1'b1, 1'b0, 3'b010, 3'd5, mk(0,0,0,0,0,0,1,0,0,2'b10));
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mul: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("FAIL mul_count: cnt=%0d, want 1", instr_count);
        end
    endtask

    task automatic test_lwi();
        exp_t e, o;
        push(1'b0, 1'b1, 1'b0, 3'b011, 3'd1, SB_FD);
        push(1'b0, 1'b1, 1'b0, 3'b011, 3'd2, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b011, 3'd3, SB_0);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 3'b011, 3'd4, SB_FW);
        push(1'b0, 1'b1, 1'b0, 3'b011, 3'd4, SB_FW);
        push(1'b0, 1'b1, 1'b0, 3'b011, 3'd5, mk(0,0,0,0,0,0,0,1,0,2'b00));
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lwi: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (instr_count !== 16'd2) begin
            errors++;
            $display("FAIL lwi_count: cnt=%0d, want 2", instr_count);
        end
    endtask

    task automatic test_bne();
        exp_t e, o;
        push(1'b0, 1'b1, 1'b0, 3'b101, 3'd1, SB_FD);
        push(1'b0, 1'b1, 1'b0, 3'b101, 3'd2, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b101, 3'd3, mk(0,0,0,0,1,1,0,0,0,2'b01));
        push(1'b0, 1'b1, 1'b1, 3'b101, 3'd1, SB_FD);
        push(1'b0, 1'b1, 1'b1, 3'b101, 3'd2, SB_0);
        push(1'b0, 1'b1, 1'b1, 3'b101, 3'd3, mk(0,0,0,0,0,0,0,0,0,2'b01));
        push(1'b0, 1'b1, 1'b0, 3'b100, 3'd1, SB_FD);
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bne: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
        checks++;
        if (instr_count !== 16'd4) begin
            errors++;
            $display("FAIL bne_count: cnt=%0d, want 4", instr_count);
        end
    endtask

    // Continues the swi whose FETCH closed test_bne, then a send.
    task automatic test_back_to_back();
        exp_t e, o;
        push(1'b0, 1'b1, 1'b0, 3'b100, 3'd2, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b100, 3'd3, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b100, 3'd4, mk(1,0,1,0,0,0,0,0,0,2'b00));
        push(1'b0, 1'b1, 1'b0, 3'b111, 3'd1, SB_FD);
        push(1'b0, 1'b1, 1'b0, 3'b111, 3'd2, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b111, 3'd3, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b111, 3'd5, mk(0,0,0,0,0,0,1,0,1,2'b00));
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (instr_count !== 16'd6) begin
            errors++;
            $display("FAIL b2b_count: cnt=%0d, want 6", instr_count);
        end
    endtask

    task automatic test_timeout();
        exp_t e, o;
        for (int i = 0; i < 15; i++) push(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, SB_FW);
        push(1'b0, 1'b0, 1'b0, 3'd0, 3'd6, SB_0);
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
        checks++;
        if ({err, halted, instr_count} !== {1'b1, 1'b1, 16'd6}) begin
            errors++;
            $display("FAIL timeout_status: err=%b halted=%b cnt=%0d, want 1 1 6",
                     err, halted, instr_count);
        end
        do_reset();
        push(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, SB_0);
        for (int i = 0; i < 14; i++) push(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, SB_FW);
        push(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, SB_FD);
        push(1'b0, 1'b1, 1'b0, 3'd0, 3'd2, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'd0, 3'd3, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'd0, 3'd5, mk(0,0,0,0,0,0,1,0,0,2'b00));
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL edge_ready: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if ({err, halted, instr_count} !== {1'b0, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL edge_status: err=%b halted=%b cnt=%0d, want 0 0 1",
                     err, halted, instr_count);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        push(1'b0, 1'b1, 1'b0, 3'b011, 3'd1, SB_FD);
        push(1'b0, 1'b1, 1'b0, 3'b011, 3'd2, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b011, 3'd3, SB_0);
        push(1'b0, 1'b0, 1'b0, 3'b011, 3'd4, SB_FW);
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_run: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_state: state=%0d, want 0", state);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== '{3'd0, 11'd0}) begin
            errors++;
            $display("FAIL mid_reset_after: state=%0d strobes=%b, want 0/0", o.st, o.sb);
        end
        checks++;
        if ({halted, err, instr_count} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset_status: halted=%b err=%b cnt=%0d, want 0 0 0",
                     halted, err, instr_count);
        end
    endtask

    task automatic test_halt();
        exp_t e, o;
        push(1'b1, 1'b1, 1'b0, 3'b110, 3'd0, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b110, 3'd1, SB_FD);
        push(1'b0, 1'b1, 1'b0, 3'b110, 3'd2, SB_0);
        push(1'b1, 1'b1, 1'b0, 3'b110, 3'd6, SB_0);
        push(1'b0, 1'b1, 1'b0, 3'b110, 3'd6, SB_0);
        push(1'b1, 1'b0, 1'b0, 3'b000, 3'd6, SB_0);
        push(1'b0, 1'b0, 1'b0, 3'b000, 3'd6, SB_0);
        while (eq.size() != 0) begin
            apply();
            e = eq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL halt: state=%0d strobes=%b, want state=%0d strobes=%b",
                         o.st, o.sb, e.st, e.sb);
            end
        end
        checks++;
        if ({halted, err, instr_count} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL halt_status: halted=%b err=%b cnt=%0d, want 1 0 0",
                     halted, err, instr_count);
        end
    endtask

    initial begin
        SB_0  = mk(0,0,0,0,0,0,0,0,0,2'b00);
        SB_FW = mk(1,1,0,0,0,0,0,0,0,2'b00);
        SB_FD = mk(1,1,0,1,1,0,0,0,0,2'b00);
        test_reset();
        test_mul();
        test_lwi();
        test_bne();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nanorisc_multicycle_ctrl.md
Name: nanorisc_multicycle_ctrl

Overview:
Multi-cycle sequencer for the NanoRisc core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes: PC, IR, register file, ULA and memory. Uses one request/ready memory handshake for both instruction and data access. Adds halt handling, a memory-timeout error and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, consecutive cycles without mem_ready in FETCH or MEM before a fault (>=1)
CNT_W, 16, width of the retired-instruction counter

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  leave IDLE and begin fetching
opcode  in  3  IR[opcode]; valid from DECODE onward
zero  in  1  ULA zero flag, sampled in EXEC for bne
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
MemRead  out  1  read access (fetch or lwi)
MemWrite  out  1  write access (swi)
IRWrite  out  1  load IR from memory data
PCWrite  out  1  update PC
PCSrc  out  1  0 = PC+1, 1 = branch target
RegWrite  out  1  write ULA/send result to register file
RegMemWrite  out  1  write memory data to register file
isSend  out  1  select send path as register write source
ULAOp  out  2  00 add, 01 sub, 10 mul
halted  out  1  core stopped (halt or fault)
err  out  1  memory timeout fault
instr_count  out  CNT_W  retired instructions, saturating
state  out  3  current state, for debug

Behaviour:
- State encoding (fixed): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is illegal and goes to HALT with err=1.
- Reset: state=IDLE; op_q=000; wait counter=0; halted=0; err=0; instr_count=0.
- Reset with all combinational strobes low.
- Reset mid-operation aborts immediately; no strobe is asserted in the cycle after reset.
- Registered outputs: halted, err, instr_count, state.
- Combinational strobes: decoded from state, op_q, mem_ready and zero. Any strobe not listed for a state is 0. ULAOp=00 unless listed. Strobes are never X.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: mem_req=1, MemRead=1. When mem_ready=1 in the same cycle: IRWrite=1, PCWrite=1, PCSrc=0, next state DECODE.
- DECODE: op_q <= opcode. Next state: 110 (halt) -> HALT; any other opcode -> EXEC.
- EXEC, by op_q:
  - 000/001/010 (sum/sub/mul): ULAOp = 00/01/10 respectively -> WB.
  - 101 (bne): ULAOp=01. If zero=0: PCWrite=1, PCSrc=1. Counts as retired. -> FETCH.
  - 011 (lwi) or 100 (swi): -> MEM.
  - 111 (send): -> WB.
- MEM: mem_req=1 held.
  - lwi: MemRead=1. On mem_ready=1 -> WB.
  - swi: MemWrite=1. On mem_ready=1 -> FETCH, counts as retired.
- WB: one cycle, then -> FETCH; counts as retired.
  - sum/sub/mul: RegWrite=1, ULAOp held at its EXEC value.
  - send: RegWrite=1, isSend=1.
  - lwi: RegMemWrite=1.
- HALT: halted=1 from the first HALT cycle on; all strobes 0; start is ignored. Only reset exits HALT. halt is not counted as retired.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments on each cycle in FETCH or MEM with mem_ready=0.
  - When it reaches MEM_TIMEOUT: next state HALT, err=1, halted=1.
  - mem_ready=1 in the cycle the limit is reached wins (normal completion, no fault).
- instr_count: +1 on each retirement and saturates at all-ones.
- Latency with mem_ready tied to 1 (cycles from entering FETCH to the next FETCH):
  - sum/sub/mul/send: 4
  - lwi: 5
  - swi: 4
  - bne: 3

Test Plan:
1. Reset, then hold start=0 for 5 cycles -> state=0 and all strobes 0; start=1 -> state=1 next cycle.
2. mem_ready=1, opcode=010 (mul) -> states 1,2,3,5 in order; ULAOp=10 in EXEC and WB; RegWrite=1 only in WB; instr_count=1 after WB.
3. opcode=011 (lwi) with mem_ready low for 3 cycles in MEM -> MemRead and mem_req held for 4 MEM cycles; RegMemWrite=1 in WB; RegWrite=0 throughout.
4. opcode=101 (bne): zero=0 -> PCWrite=1 and PCSrc=1 in EXEC; zero=1 -> PCWrite=0; both return to FETCH after 3 cycles.
5. MEM_TIMEOUT=15, mem_ready=0 in FETCH -> after 15 FETCH cycles state=6, err=1, halted=1. Repeat with mem_ready=1 on the 15th cycle -> DECODE, err=0.
6. opcode=110 -> HALT, halted=1, start pulses ignored. Separately, assert reset during MEM -> state=0 next cycle, all strobes 0, instr_count=0.
